// File: rtl/mphase_clock_gen_if.sv
// Control and status bundle for the multi-phase clock generator.
// The slave side belongs to the generator; the master side drives RUN/PW/GAP.
interface mphase_clock_gen_if #(
  parameter int NPHASE = 2,
  parameter int CW     = 4
);
  logic              RUN;
  logic [CW-1:0]     PW;
  logic [CW-1:0]     GAP;
  logic [NPHASE-1:0] PH;
  logic              O_S;
  logic [2:0]        PIDX;
  logic              CYC_START;
  logic              HALTED;

  modport master (
    output RUN, PW, GAP,
    input  PH, O_S, PIDX, CYC_START, HALTED
  );

  modport slave (
    input  RUN, PW, GAP,
    output PH, O_S, PIDX, CYC_START, HALTED
  );
endinterface

// File: rtl/mphase_clock_gen.sv
// Non-overlapping multi-phase clock generator: NPHASE one-hot phases of
// width max(PW,1) separated by GAP dead cycles, PW/GAP latched at phase 0.
module mphase_clock_gen #(
  parameter int NPHASE = 2,
  parameter int CW     = 4
) (
  input  logic             CLK,
  input  logic             RST,
  mphase_clock_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  localparam logic [2:0]        LAST_IDX = 3'(NPHASE - 1);
  localparam logic [NPHASE-1:0] PH_ONE   = 1;
  localparam logic [CW-1:0]     CNT_ONE  = 1;

  state_t            stateReg, stateNext;
  logic [CW-1:0]     cntReg, cntNext;
  logic [CW-1:0]     pwLReg, pwLNext;
  logic [CW-1:0]     gapLReg, gapLNext;
  logic [2:0]        pidxReg, pidxNext;
  logic [NPHASE-1:0] phReg, phNext;
  logic              osReg, osNext;
  logic              cycStartReg, cycStartNext;
  logic              haltedReg, haltedNext;

  logic              phaseDone;
  logic              startPhase;
  logic [2:0]        startIdx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg    <= IDLE;
      cntReg      <= '0;
      pwLReg      <= CNT_ONE;
      gapLReg     <= CNT_ONE;
      pidxReg     <= 3'd0;
      phReg       <= '0;
      osReg       <= 1'b1;
      cycStartReg <= 1'b0;
      haltedReg   <= 1'b1;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      pwLReg      <= pwLNext;
      gapLReg     <= gapLNext;
      pidxReg     <= pidxNext;
      phReg       <= phNext;
      osReg       <= osNext;
      cycStartReg <= cycStartNext;
      haltedReg   <= haltedNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    pwLNext      = pwLReg;
    gapLNext     = gapLReg;
    pidxNext     = pidxReg;
    phNext       = phReg;
    osNext       = osReg;
    cycStartNext = 1'b0;
    haltedNext   = haltedReg;
    phaseDone    = 1'b0;
    startPhase   = 1'b0;
    startIdx     = 3'd0;

    // Counters hold the number of cycles remaining including the current one.
    case (stateReg)
      IDLE: begin
        if (bus.RUN) startPhase = 1'b1;
      end
      HIGH: begin
        if (cntReg <= CNT_ONE) begin
          if (gapLReg != '0) begin
            stateNext = GAP;
            cntNext   = gapLReg;
            phNext    = '0;
          end else begin
            phaseDone = 1'b1;
          end
        end else begin
          cntNext = cntReg - CNT_ONE;
        end
      end
      GAP: begin
        if (cntReg <= CNT_ONE) phaseDone = 1'b1;
        else                   cntNext   = cntReg - CNT_ONE;
      end
      default: stateNext = IDLE;
    endcase

    // RUN only matters at the full-cycle boundary, so phases are never cut short.
    if (phaseDone) begin
      if (pidxReg != LAST_IDX) begin
        startPhase = 1'b1;
        startIdx   = pidxReg + 3'd1;
      end else if (bus.RUN) begin
        startPhase = 1'b1;
      end else begin
        stateNext  = IDLE;
        phNext     = '0;
        haltedNext = 1'b1;
        cntNext    = '0;
      end
    end

    if (startPhase) begin
      stateNext = HIGH;
      pidxNext  = startIdx;
      phNext    = PH_ONE << startIdx;
      osNext    = ~osReg;
      if (startIdx == 3'd0) begin
        pwLNext      = bus.PW;
        gapLNext     = bus.GAP;
        cntNext      = (bus.PW == '0) ? CNT_ONE : bus.PW;
        cycStartNext = 1'b1;
        haltedNext   = 1'b0;
      end else begin
        cntNext = (pwLReg == '0) ? CNT_ONE : pwLReg;
      end
    end
  end

  assign bus.PH        = phReg;
  assign bus.O_S       = osReg;
  assign bus.PIDX      = pidxReg;
  assign bus.CYC_START = cycStartReg;
  assign bus.HALTED    = haltedReg;

endmodule

// File: tb/tb_mphase_clock_gen.sv
// Randomized bench: each full cycle's waveform is planned up front as a queue
// of per-clock slots and compared with the generator every clock.
module tb_mphase_clock_gen;
  localparam int NP  = 3;
  localparam int CWP = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mphase_clock_gen_if #(.NPHASE(NP), .CW(CWP)) bus ();

  mphase_clock_gen #(.NPHASE(NP), .CW(CWP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] ph;
    int         pidx;
    bit         cs;
    bit         st;
  } slot_t;

  slot_t      schedQ[$];
  logic [7:0] expPh;
  int         expPidx;
  bit         expOs;
  bit         expCs;
  bit         expHalted;
  int         totalCnt = 0;
  int         badCnt   = 0;
  int         cycle    = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cycle, got, exp);
    end
  endtask

  // Predicts the outputs visible after the next rising edge from the inputs
  // that edge will sample.
  task automatic modelStep();
    slot_t      s;
    int         w;
    int         g;
    logic [7:0] bitv;
    if (RST) begin
      schedQ.delete();
      expPh = 8'd0; expOs = 1'b1; expPidx = 0; expCs = 1'b0; expHalted = 1'b1;
      return;
    end
    if (schedQ.size() == 0 && bus.RUN) begin
      w = (bus.PW == '0) ? 1 : int'(bus.PW);
      g = int'(bus.GAP);
      for (int p = 0; p < NP; p++) begin
        bitv = 8'd1 << p;
        for (int i = 0; i < w; i++) begin
          s.ph = bitv; s.pidx = p; s.cs = (p == 0 && i == 0); s.st = (i == 0);
          schedQ.push_back(s);
        end
        for (int i = 0; i < g; i++) begin
          s.ph = 8'd0; s.pidx = p; s.cs = 1'b0; s.st = 1'b0;
          schedQ.push_back(s);
        end
      end
    end
    if (schedQ.size() == 0) begin
      expPh = 8'd0; expCs = 1'b0; expHalted = 1'b1;
    end else begin
      s = schedQ.pop_front();
      expPh = s.ph; expPidx = s.pidx; expCs = s.cs; expHalted = 1'b0;
      if (s.st) expOs = ~expOs;
    end
  endtask

  function automatic logic [CWP-1:0] pickVal(input bit isGap);
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0:       return '0;
      1:       return 4'd1;
      2:       return 4'd2;
      3:       return isGap ? 4'd0 : 4'd3;
      4:       return 4'd15;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    RST = 1'b1; bus.RUN = 1'b0; bus.PW = 4'd1; bus.GAP = 4'd1;
    modelStep();
    for (int i = 0; i < 4000; i++) begin
      cycle = i;
      @(negedge CLK);
      checkVal("PH",        32'(bus.PH),        32'(expPh));
      checkVal("O_S",       32'(bus.O_S),       32'(expOs));
      checkVal("PIDX",      32'(bus.PIDX),      32'(expPidx));
      checkVal("CYC_START", 32'(bus.CYC_START), 32'(expCs));
      checkVal("HALTED",    32'(bus.HALTED),    32'(expHalted));
      checkVal("onehot",    32'($countones(bus.PH) <= 1), 32'd1);
      if (bus.CYC_START)
        $display("cycle start at %0d: PW=%0d GAP=%0d RUN=%0b", i, bus.PW, bus.GAP, bus.RUN);

      if (i < 3) begin
        RST = 1'b1;
      end else if (i < 40) begin
        RST = 1'b0; bus.RUN = 1'b1; bus.PW = 4'd1; bus.GAP = 4'd1;
      end else begin
        RST = ($urandom_range(0, 299) == 0);
        if (bus.RUN) bus.RUN = ($urandom_range(0, 59) != 0);
        else         bus.RUN = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 14) == 0) bus.PW  = pickVal(1'b0);
        if ($urandom_range(0, 14) == 0) bus.GAP = pickVal(1'b1);
      end
      modelStep();
    end
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end
endmodule

// File: doc/mphase_clock_gen.md
MPHASE_CLOCK_GEN -- requirements
Module: mphase_clock_gen

Interface
REQ-001 SHALL have parameter NPHASE, default 2, number of non-overlapping phase outputs (legal 2..8).
REQ-002 SHALL have parameter CW, default 4, width of the phase-width and gap configuration inputs.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port RUN  input  1  level enable; 1 = generate phases, 0 = stop at next full-cycle boundary.
REQ-006 SHALL have port PW  input  CW  phase high width in CLK cycles; 0 treated as 1.
REQ-007 SHALL have port GAP  input  CW  dead cycles after each phase, all outputs low; 0 = back-to-back phases.
REQ-008 SHALL have port PH  output  NPHASE  phase clocks; PH[0] is phase 1, PH[1] is phase 2, ...
REQ-009 SHALL have port O_S  output  1  phase-start toggle; inverts at the start of every phase.
REQ-010 SHALL have port PIDX  output  3  index of the current or most recent phase.
REQ-011 SHALL have port CYC_START  output  1  one-cycle pulse coincident with the first cycle of PH[0].
REQ-012 SHALL have port HALTED  output  1  1 while the generator is idle.

Function
REQ-013 SHALL register all outputs; no combinational path from any input to any output.
REQ-014 SHALL implement FSM states IDLE, HIGH, GAP.
REQ-015 IDLE with RUN=1 at an edge: next cycle PH=one-hot bit 0, PIDX=0, CYC_START=1, HALTED=0, O_S toggled; state HIGH.
REQ-016 SHALL latch PW and GAP only on entry to phase 0 (PWl, GAPl); changes at any other time take effect from the next phase 0.
REQ-017 HIGH: PH[PIDX]=1 for exactly max(PWl,1) cycles, then GAP if GAPl>0, else start the next phase directly.
REQ-018 GAP: PH=0 for exactly GAPl cycles, then start the next phase.
REQ-019 Next phase after PIDX<NPHASE-1: PIDX+1; after PIDX=NPHASE-1: phase 0 if RUN=1 (new latch, CYC_START), else IDLE.
REQ-020 Entering IDLE: PH=0, HALTED=1 in the cycle following the last HIGH/GAP cycle of phase NPHASE-1; PIDX holds NPHASE-1.
REQ-021 RUN=0 mid-cycle SHALL NOT truncate any phase or gap; the full cycle completes.
REQ-022 PH SHALL be one-hot or zero in every cycle, including with GAP=0.
REQ-023 Cycle period SHALL be NPHASE*(max(PWl,1)+GAPl) CLK cycles.
REQ-024 O_S SHALL toggle exactly once per phase start, with no other changes.
REQ-025 Width/gap counters SHALL count down from the latched value; no wrap-around at CW-bit maximum (PW=2^CW-1 gives that many cycles).

Reset
REQ-026 RST=1 at an edge SHALL force next cycle: PH=0, O_S=1, PIDX=0, CYC_START=0, HALTED=1, state IDLE, counters 0, PWl=1, GAPl=1.
REQ-027 RST SHALL take priority over RUN and truncate any phase in progress.
REQ-028 Release of RST with RUN=1: first phase appears the cycle after the first non-reset edge, per REQ-015.

Verification
REQ-029 Defaults: NPHASE=2, PW=1, GAP=1, RUN=1 after reset -> PH 01,00,10,00 repeating, period 4; O_S 1->0 at first PH[0] then toggling at each phase start; CYC_START every 4 cycles.
REQ-030 NPHASE=4, PW=3, GAP=0 -> each PH bit high 3 contiguous cycles, order 0-1-2-3, period 12, popcount(PH)<=1 always.
REQ-031 NPHASE=2, PW=2, GAP=2; RUN dropped in first cycle of PH[1] -> PH[1] high 2 cycles, 2 gap cycles, then HALTED=1, PH=0, no further pulses.
REQ-032 PW changed 1->4 during PH[1] -> current cycle keeps width 1; widths of 4 from next PH[0] (CYC_START marks it).
REQ-033 RST pulsed during HIGH of PH[1] -> next cycle PH=0, O_S=1, PIDX=0, HALTED=1; RUN=1 restart begins at PH[0].
REQ-034 PW=0, GAP=0, NPHASE=3 -> each phase 1 cycle, PH 001,010,100 repeating, period 3.
